vr_log_space_mgr: RTL and testbench
===================================

Name: vr_log_space_mgr

Overview:
- Allocates and frees space in the two VR log rings: the header ring (LOG_HDR_DEPTH entries) and the data ring (LOG_DEPTH lines of 64 B).
- Serves a Prepare-path alloc requester, a clean-up free requester and a view-change flush.
- Owns the head/tail pointers and first_log_op that feed vr_state.
- Keeps a per-entry line-count side RAM so a free knows how many data lines to release.

Parameters:
- LOG_DEPTH, 2048, data ring depth in 64 B lines.
- LOG_HDR_DEPTH, 2048, header ring depth in entries.
- LOG_W_BYTES, 64, bytes per data line.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- alloc_req_val  in  1  alloc request valid
- alloc_req_op_num  in  64  opnum of the entry
- alloc_req_bytes  in  64  payload length in bytes
- alloc_req_rdy  out  1  alloc request accepted
- alloc_resp_val  out  1  response valid
- alloc_resp_ok  out  1  1 = space granted
- alloc_resp_err  out  2  0 none, 1 hdr full, 2 data full, 3 opnum mismatch
- alloc_resp_hdr_addr  out  LOG_HDR_DEPTH_W  header slot
- alloc_resp_data_addr  out  LOG_DEPTH_W  first data line
- alloc_resp_rdy  in  1  response consumed
- free_req_val  in  1  free request valid
- free_up_to_op  in  64  free all ops strictly below this opnum
- free_req_rdy  out  1  free request accepted
- free_done  out  1  one-cycle pulse when the free completes
- flush_val  in  1  flush request
- flush_first_op  in  64  new first_log_op after flush
- flush_rdy  out  1  flush accepted
- hdr_log_head, hdr_log_tail  out  LOG_HDR_DEPTH_W+1 each  header pointers, with wrap bit
- data_log_head, data_log_tail  out  LOG_DEPTH_W+1 each  data pointers, with wrap bit
- first_log_op  out  64  oldest opnum held in the log

Behaviour:
- Reset: all pointers 0, first_log_op 0, all val/rdy/done outputs 0, FSM in IDLE. Reset mid-operation discards any pending response or free.
- Occupancy arithmetic (modulo 2^(W+1)):
  - hdr_cnt = hdr_tail − hdr_head; data_cnt = data_tail − data_head.
  - Header ring is full when hdr_cnt == LOG_HDR_DEPTH; it is empty when hdr_cnt == 0.
  - Memory addresses are the pointers with the wrap bit dropped.
  - A single entry's data lines may wrap past the end of the ring.
- Line count: lines = ceil(bytes/64), computed at 64 bits.
  - A 0-byte payload uses 0 lines; data_addr is still data_tail.
- FSM states: IDLE, ALLOC_RESP, FREE_RD, FREE_UPD.
- IDLE priority:
  - flush_val wins over everything.
  - If alloc_req_val and free_req_val arrive together, round-robin: the grant goes to whichever was not granted last. The pointer toggles only on a grant.
  - rdy outputs are combinational and asserted only for the granted requester while in IDLE.
- Alloc accepted (same cycle), checks in this order:
  1. op_num ≠ first_log_op + hdr_cnt → err 3.
  2. hdr_cnt == LOG_HDR_DEPTH → err 1.
  3. lines > LOG_DEPTH − data_cnt → err 2.
- On success:
  - Register hdr_addr = hdr_tail and data_addr = data_tail.
  - Write lines into side_ram[hdr_tail].
  - hdr_tail += 1; data_tail += lines.
- On failure: no state change.
- Either way go to ALLOC_RESP. resp_val rises the cycle after acceptance and is held stable until resp_rdy; then return to IDLE.
- Free accepted:
  - Latch free_up_to_op.
  - Loop while hdr_cnt > 0 and first_log_op < latched op:
    - FREE_RD reads side_ram[hdr_head] (1-cycle latency).
    - FREE_UPD does data_head += lines, hdr_head += 1, first_log_op += 1.
    - Cost is 2 cycles per entry.
  - Loop exit pulses free_done for 1 cycle, then IDLE.
  - A free with nothing to release pulses free_done the cycle after acceptance.
- Flush accepted (IDLE only):
  - Same cycle: heads := tails (both rings empty) and first_log_op := flush_first_op.
  - The rings do not rewind; tails are unchanged.
- Invariants (assert):
  - data_cnt ≤ LOG_DEPTH; hdr_cnt ≤ LOG_HDR_DEPTH.
  - Response payload is stable while resp_val && !resp_rdy.

Decomposition:
- Shared package (beehive_vr_pkg): LOG_DEPTH(_W), LOG_HDR_DEPTH(_W), LOG_W_BYTES(_W), plus a new alloc_err_e enum {ALLOC_OK, HDR_FULL, DATA_FULL, OP_MISMATCH}.
- Sub-module vr_log_len_ram:
  - LOG_HDR_DEPTH × (LOG_DEPTH_W+1) simple dual-port RAM.
  - One write port, one read port, registered read.

Test Plan:
- After reset, alloc op 0, 130 B → ok, hdr_addr 0, data_addr 0; then data_tail=3, hdr_tail=1; resp_val held 4 cycles with resp_rdy=0 and stays stable.
- Allocs of ops 0..2047 at 64 B each → all ok; op 2048 → err HDR_FULL; pointers unchanged.
- Alloc op 0 with 131072 B → ok, data ring full; next alloc op 1 with 1 B → err DATA_FULL; op 1 with 0 B → ok.
- From first_log_op=5, alloc op 7 → err OP_MISMATCH.
- Ops 0..3 of 64/128/0/200 B, then free_up_to_op=3 → 3 entries freed in 6 cycles; data_head=3, first_log_op=3, single free_done; then free_up_to_op=2 → free_done next cycle, nothing freed.
- Alloc and free asserted together twice → granted alternately. Wrap test: run tails past 2048 → addresses wrap to 0, wrap bit set, occupancy correct. Flush with op 100 → heads==tails, first_log_op=100; next alloc op 100 → ok.

Source files
------------

// File: rtl/beehive_vr_pkg.sv
// Shared VR log constants, alloc error codes and the byte-to-line helper.
package beehive_vr_pkg;

  localparam int LOG_DEPTH       = 2048;
  localparam int LOG_DEPTH_W     = $clog2(LOG_DEPTH);
  localparam int LOG_HDR_DEPTH   = 2048;
  localparam int LOG_HDR_DEPTH_W = $clog2(LOG_HDR_DEPTH);
  localparam int LOG_W_BYTES     = 64;
  localparam int LOG_W_BYTES_W   = $clog2(LOG_W_BYTES);

  typedef enum logic [1:0] {
    ALLOC_OK    = 2'd0,
    HDR_FULL    = 2'd1,
    DATA_FULL   = 2'd2,
    OP_MISMATCH = 2'd3
  } alloc_err_e;

  // ceil(bytes / LOG_W_BYTES) without forming bytes + 63, which could overflow.
  function automatic logic [63:0] log_lines(input logic [63:0] bytes);
    return (bytes >> LOG_W_BYTES_W) + {63'd0, |bytes[LOG_W_BYTES_W-1:0]};
  endfunction

endpackage

// File: rtl/vr_log_space_mgr_if.sv
// Alloc / free / flush handshakes between the log clients and the space manager.
interface vr_log_space_mgr_if;
  import beehive_vr_pkg::*;

  logic                       alloc_req_val;
  logic [63:0]                alloc_req_op_num;
  logic [63:0]                alloc_req_bytes;
  logic                       alloc_req_rdy;
  logic                       alloc_resp_val;
  logic                       alloc_resp_ok;
  alloc_err_e                 alloc_resp_err;
  logic [LOG_HDR_DEPTH_W-1:0] alloc_resp_hdr_addr;
  logic [LOG_DEPTH_W-1:0]     alloc_resp_data_addr;
  logic                       alloc_resp_rdy;
  logic                       free_req_val;
  logic [63:0]                free_up_to_op;
  logic                       free_req_rdy;
  logic                       free_done;
  logic                       flush_val;
  logic [63:0]                flush_first_op;
  logic                       flush_rdy;

  modport master (
    output alloc_req_val, alloc_req_op_num, alloc_req_bytes, alloc_resp_rdy,
    output free_req_val, free_up_to_op, flush_val, flush_first_op,
    input  alloc_req_rdy, alloc_resp_val, alloc_resp_ok, alloc_resp_err,
    input  alloc_resp_hdr_addr, alloc_resp_data_addr, free_req_rdy, free_done, flush_rdy
  );

  modport slave (
    input  alloc_req_val, alloc_req_op_num, alloc_req_bytes, alloc_resp_rdy,
    input  free_req_val, free_up_to_op, flush_val, flush_first_op,
    output alloc_req_rdy, alloc_resp_val, alloc_resp_ok, alloc_resp_err,
    output alloc_resp_hdr_addr, alloc_resp_data_addr, free_req_rdy, free_done, flush_rdy
  );

endinterface

// File: rtl/vr_log_len_ram.sv
// Per-header-entry data line count, written at alloc and read back at free.
module vr_log_len_ram
  import beehive_vr_pkg::*;
(
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [LOG_HDR_DEPTH_W-1:0] wr_addr,
  input  logic [LOG_DEPTH_W:0]       wr_data,
  input  logic                       rd_en,
  input  logic [LOG_HDR_DEPTH_W-1:0] rd_addr,
  output logic [LOG_DEPTH_W:0]       rd_data
);

  logic [LOG_DEPTH_W:0] mem [LOG_HDR_DEPTH];

  // Write port.
  // NOTE: the array has no reset so it maps onto block RAM; entries are only read after being written.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vr_log_space_mgr.sv
// Header/data ring allocator: grants alloc, frees by opnum, flushes on view change.
module vr_log_space_mgr
  import beehive_vr_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  vr_log_space_mgr_if.slave        bus,
  output logic [LOG_HDR_DEPTH_W:0] hdr_log_head,
  output logic [LOG_HDR_DEPTH_W:0] hdr_log_tail,
  output logic [LOG_DEPTH_W:0]     data_log_head,
  output logic [LOG_DEPTH_W:0]     data_log_tail,
  output logic [63:0]              first_log_op
);

  localparam int HP_W = LOG_HDR_DEPTH_W + 1;
  localparam int DP_W = LOG_DEPTH_W + 1;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_ALLOC_RESP = 2'd1;
  localparam logic [1:0] S_FREE_RD    = 2'd2;
  localparam logic [1:0] S_FREE_UPD   = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [HP_W-1:0]            hdr_head_q, hdr_head_d, hdr_tail_q, hdr_tail_d;
  logic [DP_W-1:0]            data_head_q, data_head_d, data_tail_q, data_tail_d;
  logic [63:0]                first_op_q, first_op_d, free_op_q, free_op_d;
  logic                       rr_free_last_q, rr_free_last_d;
  logic                       resp_ok_q, resp_ok_d;
  alloc_err_e                 resp_err_q, resp_err_d;
  logic [LOG_HDR_DEPTH_W-1:0] resp_hdr_addr_q, resp_hdr_addr_d;
  logic [LOG_DEPTH_W-1:0]     resp_data_addr_q, resp_data_addr_d;

  logic [HP_W-1:0] hdr_cnt;
  logic [DP_W-1:0] data_cnt;
  logic [63:0]     alloc_lines, data_free;
  alloc_err_e      alloc_err;
  logic            in_idle, flush_gnt, alloc_gnt, free_gnt, free_more;
  logic [DP_W-1:0] len_rd_data;

  assign hdr_cnt     = hdr_tail_q - hdr_head_q;
  assign data_cnt    = data_tail_q - data_head_q;
  assign alloc_lines = log_lines(bus.alloc_req_bytes);
  assign data_free   = 64'(LOG_DEPTH) - 64'(data_cnt);
  assign free_more   = (hdr_cnt != '0) && (first_op_q < free_op_q);

  // Flush beats everything; alloc vs free contention goes to whoever lost last time.
  assign in_idle   = (state_q == S_IDLE);
  assign flush_gnt = in_idle && bus.flush_val;
  assign alloc_gnt = in_idle && !bus.flush_val && bus.alloc_req_val && (!bus.free_req_val || rr_free_last_q);
  assign free_gnt  = in_idle && !bus.flush_val && bus.free_req_val && (!bus.alloc_req_val || !rr_free_last_q);

  // Alloc checks in priority order: opnum sequence, header space, data space.
  always_comb begin
    alloc_err = ALLOC_OK;
    if (bus.alloc_req_op_num != first_op_q + 64'(hdr_cnt)) alloc_err = OP_MISMATCH;
    else if (hdr_cnt == HP_W'(LOG_HDR_DEPTH))               alloc_err = HDR_FULL;
    else if (alloc_lines > data_free)                       alloc_err = DATA_FULL;
  end

  vr_log_len_ram u_len_ram (
    .clk     (clk),
    .wr_en   (alloc_gnt && (alloc_err == ALLOC_OK)),
    .wr_addr (hdr_tail_q[LOG_HDR_DEPTH_W-1:0]),
    .wr_data (alloc_lines[DP_W-1:0]),
    .rd_en   (state_q == S_FREE_RD),
    .rd_addr (hdr_head_q[LOG_HDR_DEPTH_W-1:0]),
    .rd_data (len_rd_data)
  );

  // Next-state and pointer updates for the control FSM.
  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d          = state_q;
    hdr_head_d       = hdr_head_q;
    hdr_tail_d       = hdr_tail_q;
    data_head_d      = data_head_q;
    data_tail_d      = data_tail_q;
    first_op_d       = first_op_q;
    free_op_d        = free_op_q;
    rr_free_last_d   = rr_free_last_q;
    resp_ok_d        = resp_ok_q;
    resp_err_d       = resp_err_q;
    resp_hdr_addr_d  = resp_hdr_addr_q;
    resp_data_addr_d = resp_data_addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (flush_gnt) begin
          hdr_head_d  = hdr_tail_q;
          data_head_d = data_tail_q;
          first_op_d  = bus.flush_first_op;
        end else if (alloc_gnt) begin
          rr_free_last_d = 1'b0;
          resp_ok_d      = (alloc_err == ALLOC_OK);
          resp_err_d     = alloc_err;
          if (alloc_err == ALLOC_OK) begin
            resp_hdr_addr_d  = hdr_tail_q[LOG_HDR_DEPTH_W-1:0];
            resp_data_addr_d = data_tail_q[LOG_DEPTH_W-1:0];
            hdr_tail_d       = hdr_tail_q + 1'b1;
            data_tail_d      = data_tail_q + alloc_lines[DP_W-1:0];
          end
          state_d = S_ALLOC_RESP;
        end else if (free_gnt) begin
          rr_free_last_d = 1'b1;
          free_op_d      = bus.free_up_to_op;
          state_d        = S_FREE_RD;
        end
      end
      S_ALLOC_RESP: if (bus.alloc_resp_rdy) state_d = S_IDLE;
      S_FREE_RD:    state_d = free_more ? S_FREE_UPD : S_IDLE;
      S_FREE_UPD: begin
        data_head_d = data_head_q + len_rd_data;
        hdr_head_d  = hdr_head_q + 1'b1;
        first_op_d  = first_op_q + 64'd1;
        state_d     = S_FREE_RD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight response or free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      hdr_head_q       <= '0;
      hdr_tail_q       <= '0;
      data_head_q      <= '0;
      data_tail_q      <= '0;
      first_op_q       <= '0;
      free_op_q        <= '0;
      rr_free_last_q   <= 1'b1;
      resp_ok_q        <= 1'b0;
      resp_err_q       <= ALLOC_OK;
      resp_hdr_addr_q  <= '0;
      resp_data_addr_q <= '0;
    end else begin
      state_q          <= state_d;
      hdr_head_q       <= hdr_head_d;
      hdr_tail_q       <= hdr_tail_d;
      data_head_q      <= data_head_d;
      data_tail_q      <= data_tail_d;
      first_op_q       <= first_op_d;
      free_op_q        <= free_op_d;
      rr_free_last_q   <= rr_free_last_d;
      resp_ok_q        <= resp_ok_d;
      resp_err_q       <= resp_err_d;
      resp_hdr_addr_q  <= resp_hdr_addr_d;
      resp_data_addr_q <= resp_data_addr_d;
    end
  end

  assign bus.alloc_req_rdy        = alloc_gnt;
  assign bus.free_req_rdy         = free_gnt;
  assign bus.flush_rdy            = flush_gnt;
  assign bus.alloc_resp_val       = (state_q == S_ALLOC_RESP);
  assign bus.alloc_resp_ok        = resp_ok_q;
  assign bus.alloc_resp_err       = resp_err_q;
  assign bus.alloc_resp_hdr_addr  = resp_hdr_addr_q;
  assign bus.alloc_resp_data_addr = resp_data_addr_q;
  assign bus.free_done            = (state_q == S_FREE_RD) && !free_more;

  assign hdr_log_head  = hdr_head_q;
  assign hdr_log_tail  = hdr_tail_q;
  assign data_log_head = data_head_q;
  assign data_log_tail = data_tail_q;
  assign first_log_op  = first_op_q;

  // Rings never overfill, and a stalled response keeps its payload.
  a_occupancy: assert property (@(posedge clk) disable iff (rst)
    (hdr_cnt <= HP_W'(LOG_HDR_DEPTH)) && (data_cnt <= DP_W'(LOG_DEPTH)));
  a_resp_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.alloc_resp_val && !bus.alloc_resp_rdy) |=>
      $stable({bus.alloc_resp_ok, bus.alloc_resp_err, bus.alloc_resp_hdr_addr, bus.alloc_resp_data_addr}));

endmodule

// File: tb/tb_vr_log_space_mgr.sv
// Directed bench for vr_log_space_mgr: alloc, full conditions, free, round-robin, wrap, flush, reset.
module tb_vr_log_space_mgr;
  import beehive_vr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [LOG_HDR_DEPTH_W:0] hdr_log_head, hdr_log_tail;
  logic [LOG_DEPTH_W:0]     data_log_head, data_log_tail;
  logic [63:0]              first_log_op;
  int total = 0;
  int bad   = 0;

  vr_log_space_mgr_if lsm_if ();

  vr_log_space_mgr dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (lsm_if),
    .hdr_log_head  (hdr_log_head),
    .hdr_log_tail  (hdr_log_tail),
    .data_log_head (data_log_head),
    .data_log_tail (data_log_tail),
    .first_log_op  (first_log_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    lsm_if.alloc_req_val    = 1'b0;
    lsm_if.alloc_req_op_num = '0;
    lsm_if.alloc_req_bytes  = '0;
    lsm_if.alloc_resp_rdy   = 1'b0;
    lsm_if.free_req_val     = 1'b0;
    lsm_if.free_up_to_op    = '0;
    lsm_if.flush_val        = 1'b0;
    lsm_if.flush_first_op   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic check_ptrs(input string tag, input logic [63:0] hh, input logic [63:0] ht,
                            input logic [63:0] dh, input logic [63:0] dt, input logic [63:0] fo);
    check({tag, ".hdr_head"}, 64'(hdr_log_head), hh);
    check({tag, ".hdr_tail"}, 64'(hdr_log_tail), ht);
    check({tag, ".data_head"}, 64'(data_log_head), dh);
    check({tag, ".data_tail"}, 64'(data_log_tail), dt);
    check({tag, ".first_op"}, first_log_op, fo);
  endtask

  // Issue one alloc, check the response, consume it.
  task automatic alloc(input logic [63:0] op, input logic [63:0] bytes, input alloc_err_e exp_err,
                       input logic [63:0] exp_hdr, input logic [63:0] exp_data);
    lsm_if.alloc_req_op_num = op;
    lsm_if.alloc_req_bytes  = bytes;
    lsm_if.alloc_req_val    = 1'b1;
    #1;
    check("alloc_rdy", 64'(lsm_if.alloc_req_rdy), 64'd1);
    step();
    lsm_if.alloc_req_val = 1'b0;
    check("resp_val", 64'(lsm_if.alloc_resp_val), 64'd1);
    check("resp_ok", 64'(lsm_if.alloc_resp_ok), 64'(exp_err == ALLOC_OK));
    check("resp_err", 64'(lsm_if.alloc_resp_err), 64'(exp_err));
    if (exp_err == ALLOC_OK) begin
      check("resp_hdr_addr", 64'(lsm_if.alloc_resp_hdr_addr), exp_hdr);
      check("resp_data_addr", 64'(lsm_if.alloc_resp_data_addr), exp_data);
    end
    lsm_if.alloc_resp_rdy = 1'b1;
    step();
    lsm_if.alloc_resp_rdy = 1'b0;
    check("resp_val_drop", 64'(lsm_if.alloc_resp_val), 64'd0);
  endtask

  // Issue one free; count cycles from acceptance to free_done (bounded).
  task automatic free_to(input logic [63:0] op, input int exp_cycles);
    int n;
    lsm_if.free_up_to_op = op;
    lsm_if.free_req_val  = 1'b1;
    #1;
    check("free_rdy", 64'(lsm_if.free_req_rdy), 64'd1);
    step();
    lsm_if.free_req_val = 1'b0;
    n = 0;
    while (!lsm_if.free_done && n < 100) begin
      step();
      n++;
    end
    check("free_cycles", 64'(n), 64'(exp_cycles));
    step();
    check("free_done_pulse", 64'(lsm_if.free_done), 64'd0);
  endtask

  initial begin
    clear_inputs();

    // Reset state.
    do_reset();
    check_ptrs("reset", 0, 0, 0, 0, 0);
    check("reset.alloc_rdy", 64'(lsm_if.alloc_req_rdy), 0);
    check("reset.free_rdy", 64'(lsm_if.free_req_rdy), 0);
    check("reset.flush_rdy", 64'(lsm_if.flush_rdy), 0);
    check("reset.resp_val", 64'(lsm_if.alloc_resp_val), 0);
    check("reset.free_done", 64'(lsm_if.free_done), 0);

    // Alloc op 0, 130 B -> 3 lines; response held stable under backpressure.
    lsm_if.alloc_req_op_num = 64'd0;
    lsm_if.alloc_req_bytes  = 64'd130;
    lsm_if.alloc_req_val    = 1'b1;
    #1;
    check("t1.alloc_rdy", 64'(lsm_if.alloc_req_rdy), 1);
    step();
    lsm_if.alloc_req_val = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("t1.hold_val", 64'(lsm_if.alloc_resp_val), 1);
      check("t1.hold_ok", 64'(lsm_if.alloc_resp_ok), 1);
      check("t1.hold_err", 64'(lsm_if.alloc_resp_err), 0);
      check("t1.hold_hdr", 64'(lsm_if.alloc_resp_hdr_addr), 0);
      check("t1.hold_data", 64'(lsm_if.alloc_resp_data_addr), 0);
      step();
    end
    check_ptrs("t1", 0, 1, 0, 3, 0);
    lsm_if.alloc_resp_rdy = 1'b1;
    step();
    lsm_if.alloc_resp_rdy = 1'b0;
    check("t1.resp_done", 64'(lsm_if.alloc_resp_val), 0);

    // Fill the header ring, then one more -> HDR_FULL with no pointer change.
    do_reset();
    for (int i = 0; i < 2048; i++) alloc(64'(i), 64'd64, ALLOC_OK, 64'(i), 64'(i));
    check_ptrs("t2.full", 0, 12'h800, 0, 12'h800, 0);
    alloc(64'd2048, 64'd64, HDR_FULL, 0, 0);
    check_ptrs("t2.after", 0, 12'h800, 0, 12'h800, 0);

    // Fill the data ring in one entry; 1 B does not fit, 0 B does.
    do_reset();
    alloc(64'd0, 64'd131072, ALLOC_OK, 0, 0);
    check_ptrs("t3.full", 0, 1, 0, 12'h800, 0);
    alloc(64'd1, 64'd1, DATA_FULL, 0, 0);
    alloc(64'd1, 64'd0, ALLOC_OK, 1, 0);
    check_ptrs("t3.zero", 0, 2, 0, 12'h800, 0);

    // Opnum mismatch with first_log_op = 5.
    do_reset();
    lsm_if.flush_first_op = 64'd5;
    lsm_if.flush_val      = 1'b1;
    #1;
    check("t4.flush_rdy", 64'(lsm_if.flush_rdy), 1);
    step();
    lsm_if.flush_val = 1'b0;
    check_ptrs("t4.flush", 0, 0, 0, 0, 5);
    alloc(64'd7, 64'd64, OP_MISMATCH, 0, 0);
    check_ptrs("t4.after", 0, 0, 0, 0, 5);
    alloc(64'd5, 64'd64, ALLOC_OK, 0, 0);

    // Four entries of 1/2/0/4 lines, free below op 3, then an empty free.
    do_reset();
    alloc(64'd0, 64'd64,  ALLOC_OK, 0, 0);
    alloc(64'd1, 64'd128, ALLOC_OK, 1, 1);
    alloc(64'd2, 64'd0,   ALLOC_OK, 2, 3);
    alloc(64'd3, 64'd200, ALLOC_OK, 3, 3);
    check_ptrs("t5.alloc", 0, 4, 0, 7, 0);
    free_to(64'd3, 6);
    check_ptrs("t5.free", 3, 4, 3, 7, 3);
    free_to(64'd2, 0);
    check_ptrs("t5.nofree", 3, 4, 3, 7, 3);

    // Contention: last grant was free, so alloc wins first, then free.
    lsm_if.alloc_req_op_num = 64'd4;
    lsm_if.alloc_req_bytes  = 64'd64;
    lsm_if.alloc_req_val    = 1'b1;
    lsm_if.free_up_to_op    = 64'd3;
    lsm_if.free_req_val     = 1'b1;
    #1;
    check("t6.rr1_alloc", 64'(lsm_if.alloc_req_rdy), 1);
    check("t6.rr1_free", 64'(lsm_if.free_req_rdy), 0);
    step();
    lsm_if.alloc_req_val = 1'b0;
    check("t6.resp_ok", 64'(lsm_if.alloc_resp_ok), 1);
    check("t6.resp_hdr", 64'(lsm_if.alloc_resp_hdr_addr), 4);
    check("t6.resp_data", 64'(lsm_if.alloc_resp_data_addr), 7);
    lsm_if.alloc_resp_rdy = 1'b1;
    step();
    lsm_if.alloc_resp_rdy   = 1'b0;
    lsm_if.alloc_req_op_num = 64'd5;
    lsm_if.alloc_req_val    = 1'b1;
    #1;
    check("t6.rr2_alloc", 64'(lsm_if.alloc_req_rdy), 0);
    check("t6.rr2_free", 64'(lsm_if.free_req_rdy), 1);
    step();
    lsm_if.alloc_req_val = 1'b0;
    lsm_if.free_req_val  = 1'b0;
    check("t6.free_done", 64'(lsm_if.free_done), 1);
    step();
    check_ptrs("t6.end", 3, 5, 3, 8, 3);

    // Data ring wrap: tails run past 2048, addresses restart at 0.
    do_reset();
    alloc(64'd0, 64'd98304, ALLOC_OK, 0, 0);
    free_to(64'd1, 2);
    check_ptrs("t7.free", 1, 1, 12'h600, 12'h600, 1);
    alloc(64'd1, 64'd65536, ALLOC_OK, 1, 12'h600);
    check_ptrs("t7.wrap", 1, 2, 12'h600, 12'hA00, 1);
    alloc(64'd2, 64'd64, ALLOC_OK, 2, 12'h200);
    alloc(64'd3, 64'd65536, DATA_FULL, 0, 0);
    alloc(64'd3, 64'd65472, ALLOC_OK, 3, 12'h201);
    check_ptrs("t7.full", 1, 4, 12'h600, 12'hE00, 1);

    // Flush wins over a concurrent alloc; heads jump to tails.
    lsm_if.flush_first_op   = 64'd100;
    lsm_if.flush_val        = 1'b1;
    lsm_if.alloc_req_op_num = 64'd100;
    lsm_if.alloc_req_bytes  = 64'd64;
    lsm_if.alloc_req_val    = 1'b1;
    #1;
    check("t8.flush_rdy", 64'(lsm_if.flush_rdy), 1);
    check("t8.alloc_blocked", 64'(lsm_if.alloc_req_rdy), 0);
    step();
    lsm_if.flush_val     = 1'b0;
    lsm_if.alloc_req_val = 1'b0;
    check_ptrs("t8.flush", 4, 4, 12'hE00, 12'hE00, 100);
    alloc(64'd100, 64'd64, ALLOC_OK, 4, 12'h600);
    check_ptrs("t8.alloc", 4, 5, 12'hE00, 12'hE01, 100);

    // Reset while a response is pending discards it.
    lsm_if.alloc_req_op_num = 64'd101;
    lsm_if.alloc_req_bytes  = 64'd64;
    lsm_if.alloc_req_val    = 1'b1;
    step();
    lsm_if.alloc_req_val = 1'b0;
    check("t9.pending", 64'(lsm_if.alloc_resp_val), 1);
    rst = 1'b1;
    #1;
    check("t9.resp_cleared", 64'(lsm_if.alloc_resp_val), 0);
    check_ptrs("t9.reset", 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
